// File: rtl/lock_pkg.sv
// Shared types and constants for the digital lock sequencing controller.
package lock_pkg;
  localparam int LOCK_DIGIT_W = 4;
  localparam logic [15:0] LOCK_DEFAULT_CODE = 16'h173D;

  typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} lock_state_t;
endpackage

// File: rtl/lock_seq_ctrl_if.sv
// Keypad-side bus of the lock controller; prog_* exists only with LOCK_CODE_PROG_EN.
interface lock_seq_ctrl_if
  import lock_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_TRIES  = 3
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);

  logic                    digit_valid;
  logic [LOCK_DIGIT_W-1:0] digit;
  logic                    clear;
  logic                    unlock;
  logic                    alarm;
  logic                    err;
  logic                    busy;
  logic [CW-1:0]           entry_cnt;
  logic [FW-1:0]           fail_cnt;
`ifdef LOCK_CODE_PROG_EN
  logic                                 prog_valid;
  logic [LOCK_DIGIT_W*NUM_DIGITS-1:0]   prog_code;

  modport master (output digit_valid, digit, clear, prog_valid, prog_code,
                  input  unlock, alarm, err, busy, entry_cnt, fail_cnt);
  modport slave  (input  digit_valid, digit, clear, prog_valid, prog_code,
                  output unlock, alarm, err, busy, entry_cnt, fail_cnt);
`else
  modport master (output digit_valid, digit, clear,
                  input  unlock, alarm, err, busy, entry_cnt, fail_cnt);
  modport slave  (input  digit_valid, digit, clear,
                  output unlock, alarm, err, busy, entry_cnt, fail_cnt);
`endif
endinterface

// File: rtl/lock_digit_cmp.sv
// Combinational single-digit comparator.
module lock_digit_cmp
  import lock_pkg::*;
(
  input  logic [LOCK_DIGIT_W-1:0] data1,
  input  logic [LOCK_DIGIT_W-1:0] data2,
  output logic                    equal,
  output logic                    not_equal
);
  assign equal     = (data1 == data2);
  assign not_equal = ~equal;
endmodule

// File: rtl/lock_seq_ctrl.sv
// Lock sequencing controller: digit entry, unlock/fail decision, timed lockout.
// Optional feature macro: LOCK_CODE_PROG_EN (code reprogramming while OPEN).
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES = 64,
  parameter logic [LOCK_DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = LOCK_DEFAULT_CODE
) (
  input  logic            clk,
  input  logic            rst,
  lock_seq_ctrl_if.slave  bus
);
  localparam int CW   = $clog2(NUM_DIGITS + 1);
  localparam int FW   = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  lock_state_t   state, state_n;
  logic [CW-1:0] entry_cnt, entry_n;
  logic [FW-1:0] fail_cnt, fail_n;
  logic [TW-1:0] timer, timer_n;
  logic          mismatch, mis_n, err_n;
  logic          unlock_q, alarm_q, err_q, busy_q;

  logic [NUM_DIGITS-1:0][LOCK_DIGIT_W-1:0] code;
`ifdef LOCK_CODE_PROG_EN
  always_ff @(posedge clk) begin
    if (rst)                             code <= DEFAULT_CODE;
    else if (state == OPEN && bus.prog_valid) code <= bus.prog_code;
  end
`else
  assign code = DEFAULT_CODE;
`endif

  // One shared comparator; the expected digit is selected by entry position.
  logic [LOCK_DIGIT_W-1:0] exp_digit;
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (entry_cnt == CW'(i)) exp_digit = code[i];
  end

  logic dig_eq, dig_ne;
  lock_digit_cmp u_cmp (.data1(bus.digit), .data2(exp_digit), .equal(dig_eq), .not_equal(dig_ne));

  logic accept, last;
  assign accept = bus.digit_valid && !bus.clear && (state == IDLE || state == ENTRY);
  assign last   = (entry_cnt == CW'(NUM_DIGITS - 1));

  always_comb begin
    state_n = state;
    entry_n = entry_cnt;
    mis_n   = mismatch;
    fail_n  = fail_cnt;
    timer_n = timer;
    err_n   = 1'b0;
    case (state)
      IDLE, ENTRY: begin
        if (bus.clear && state == ENTRY) begin
          state_n = IDLE;
          entry_n = '0;
          mis_n   = 1'b0;
        end else if (accept) begin
          if (last) begin
            entry_n = '0;
            mis_n   = 1'b0;
            if (dig_eq && !mismatch) begin
              state_n = OPEN;
              fail_n  = '0;
              timer_n = TW'(OPEN_CYCLES - 1);
            end else if (fail_cnt == FW'(MAX_TRIES - 1)) begin
              state_n = LOCKOUT;
              fail_n  = FW'(MAX_TRIES);
              timer_n = TW'(LOCKOUT_CYCLES - 1);
            end else begin
              state_n = IDLE;
              fail_n  = fail_cnt + FW'(1);
              err_n   = 1'b1;
            end
          end else begin
            state_n = ENTRY;
            entry_n = entry_cnt + CW'(1);
            mis_n   = mismatch | dig_ne;
          end
        end
      end
      OPEN: begin
        if (timer == '0) state_n = IDLE;
        else             timer_n = timer - TW'(1);
      end
      LOCKOUT: begin
        if (timer == '0) begin
          state_n = IDLE;
          fail_n  = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land registered with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      entry_cnt <= '0;
      fail_cnt  <= '0;
      timer     <= '0;
      mismatch  <= 1'b0;
      unlock_q  <= 1'b0;
      alarm_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      entry_cnt <= entry_n;
      fail_cnt  <= fail_n;
      timer     <= timer_n;
      mismatch  <= mis_n;
      unlock_q  <= (state_n == OPEN);
      alarm_q   <= (state_n == LOCKOUT);
      err_q     <= err_n;
      busy_q    <= (state_n == OPEN) || (state_n == LOCKOUT);
    end
  end

  assign bus.unlock    = unlock_q;
  assign bus.alarm     = alarm_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.entry_cnt = entry_cnt;
  assign bus.fail_cnt  = fail_cnt;
endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Scoreboarded bench for lock_seq_ctrl (default parameters).
module tb_lock_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lock_seq_ctrl_if #(.NUM_DIGITS(4), .MAX_TRIES(3)) bus ();
  lock_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       u, a, e;
    logic [1:0] f;
    int         dur;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic idle_inputs();
    bus.digit_valid = 1'b0;
    bus.digit       = '0;
    bus.clear       = 1'b0;
`ifdef LOCK_CODE_PROG_EN
    bus.prog_valid  = 1'b0;
    bus.prog_code   = '0;
`endif
  endtask

  task automatic enter(input logic [15:0] c, input exp_t e);
    q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.digit_valid = 1'b1;
      bus.digit       = c[4*i +: 4];
    end
    @(negedge clk);
    bus.digit_valid = 1'b0;
  endtask

  // Called on the first negedge after the decision edge; when spam is set,
  // digits are offered throughout the pulse and must never be accepted.
  task automatic check_decision(input string nm, input bit spam);
    exp_t e;
    int   n;
    bit   leaked;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = q.pop_front();
    total++;
    if ({bus.unlock, bus.alarm, bus.err} !== {e.u, e.a, e.e}) begin
      bad++;
      $display("FAIL %s flags: got u/a/e=%b%b%b want %b%b%b", nm,
               bus.unlock, bus.alarm, bus.err, e.u, e.a, e.e);
    end
    total++;
    if (bus.fail_cnt !== e.f) begin
      bad++;
      $display("FAIL %s fail_cnt: got %0d want %0d", nm, bus.fail_cnt, e.f);
    end
    n = 0;
    leaked = 1'b0;
    while ((bus.unlock || bus.alarm || bus.err) && n < 200) begin
      if (spam) begin
        bus.digit_valid = 1'b1;
        bus.digit       = 4'(n);
        if (bus.entry_cnt !== 3'd0) leaked = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    bus.digit_valid = 1'b0;
    total++;
    if (n !== e.dur) begin
      bad++;
      $display("FAIL %s duration: got %0d want %0d", nm, n, e.dur);
    end
    if (spam) begin
      total++;
      if (leaked) begin
        bad++;
        $display("FAIL %s busy_drop: entry_cnt moved during busy, want 0", nm);
      end
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s post_idle busy: got %b want 0", nm, bus.busy);
    end
  endtask

  task automatic check_all_zero(input string nm);
    total++;
    if ({bus.unlock, bus.alarm, bus.err, bus.busy, bus.entry_cnt, bus.fail_cnt} !== 9'd0) begin
      bad++;
      $display("FAIL %s: got u=%b a=%b e=%b b=%b ec=%0d fc=%0d want all 0", nm,
               bus.unlock, bus.alarm, bus.err, bus.busy, bus.entry_cnt, bus.fail_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_all_zero("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_unlock();
    enter(16'h173D, '{u:1, a:0, e:0, f:0, dur:16});
    check_decision("unlock", 1'b0);
    // first IDLE cycle after OPEN must accept a digit
    bus.digit_valid = 1'b1;
    bus.digit       = 4'hD;
    @(negedge clk);
    bus.digit_valid = 1'b0;
    total++;
    if (bus.entry_cnt !== 3'd1) begin
      bad++;
      $display("FAIL first_idle_accept: got entry_cnt=%0d want 1", bus.entry_cnt);
    end
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    total++;
    if (bus.entry_cnt !== 3'd0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL clear_entry: got entry_cnt=%0d err=%b want 0/0", bus.entry_cnt, bus.err);
    end
  endtask

  task automatic test_wrong_then_right();
    enter(16'h073D, '{u:0, a:0, e:1, f:1, dur:1});
    check_decision("wrong_last", 1'b0);
    enter(16'h173D, '{u:1, a:0, e:0, f:0, dur:16});
    check_decision("recover_unlock", 1'b0);
  endtask

  task automatic test_lockout();
    enter(16'h0000, '{u:0, a:0, e:1, f:1, dur:1});
    check_decision("lock_try1", 1'b0);
    enter(16'h0000, '{u:0, a:0, e:1, f:2, dur:1});
    check_decision("lock_try2", 1'b0);
    enter(16'h0000, '{u:0, a:1, e:0, f:3, dur:64});
    check_decision("lockout", 1'b1);
    total++;
    if (bus.fail_cnt !== 2'd0) begin
      bad++;
      $display("FAIL lockout_exit fail_cnt: got %0d want 0", bus.fail_cnt);
    end
  endtask

  task automatic test_clear_collision();
    @(negedge clk); bus.digit_valid = 1'b1; bus.digit = 4'hD;
    @(negedge clk); bus.digit = 4'h3;
    @(negedge clk); bus.digit = 4'h7; bus.clear = 1'b1;
    @(negedge clk); bus.digit_valid = 1'b0; bus.clear = 1'b0;
    total++;
    if (bus.entry_cnt !== 3'd0 || bus.err !== 1'b0 || bus.fail_cnt !== 2'd0) begin
      bad++;
      $display("FAIL clear_wins: got ec=%0d err=%b fc=%0d want 0/0/0",
               bus.entry_cnt, bus.err, bus.fail_cnt);
    end
    enter(16'h173D, '{u:1, a:0, e:0, f:0, dur:16});
    check_decision("after_clear_unlock", 1'b0);
  endtask

  task automatic test_reset_mid();
    q.push_back('{u:1, a:0, e:0, f:0, dur:0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.digit_valid = 1'b1; bus.digit = 4'(16'h173D >> (4*i));
    end
    @(negedge clk); bus.digit_valid = 1'b0;
    begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (bus.unlock !== e.u) begin
        bad++;
        $display("FAIL mid_open_pre: got unlock=%b want %b", bus.unlock, e.u);
      end
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_mid_open");
    @(negedge clk); bus.digit_valid = 1'b1; bus.digit = 4'hD;
    @(negedge clk); bus.digit = 4'h3;
    @(negedge clk); bus.digit_valid = 1'b0;
    total++;
    if (bus.entry_cnt !== 3'd2) begin
      bad++;
      $display("FAIL mid_entry_pre: got entry_cnt=%0d want 2", bus.entry_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_mid_entry");
    @(negedge clk);
    check_all_zero("reset_no_residue");
  endtask

`ifdef LOCK_CODE_PROG_EN
  task automatic test_prog();
    enter(16'h173D, '{u:1, a:0, e:0, f:0, dur:16});
    bus.prog_valid = 1'b1;
    bus.prog_code  = 16'h4321;
    check_decision("prog_open", 1'b0);
    bus.prog_valid = 1'b0;
    enter(16'h173D, '{u:0, a:0, e:1, f:1, dur:1});
    check_decision("prog_old_fails", 1'b0);
    enter(16'h4321, '{u:1, a:0, e:0, f:0, dur:16});
    check_decision("prog_new_unlocks", 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_unlock();
    test_wrong_then_right();
    test_lockout();
    test_clear_collision();
    test_reset_mid();
`ifdef LOCK_CODE_PROG_EN
    test_prog();
`endif
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
